serial_alu_ctl: RTL and testbench
=================================

Name: serial_alu_ctl

Overview:
- Bit-serial N-bit ALU built around the team's existing 1-bit ALU cell (logic unit + full adder + output mux).
- Latches two N-bit operands and an operation, then presents one bit pair per cycle to the cell, LSB first.
- Registers the cell's carry between cycles and shifts each result bit into an N-bit result register.
- Sits directly upstream of the 1-bit cell and provides the word-level interface the rest of the datapath uses.

Parameters:
- N, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  N  operand A.
- b  in  N  operand B.
- l  in  1  cell mode: 1 = arithmetic (full-adder sum), 0 = logic unit.
- s  in  2  logic-unit select, passed to the cell unchanged.
- c_in  in  1  initial carry for arithmetic ops.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  N  final word; held until the next accepted start.
- c_out  out  1  final carry of an arithmetic op; 0 for logic ops.
- zero  out  1  high when result == 0; valid whenever done or idle.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE; busy = 0, done = 0, result = 0, c_out = 0, zero = 1.
  - Shift registers, carry FF and bit counter are cleared.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start = 1 at a clock edge: load a_sr <= a, b_sr <= b, l_r <= l, s_r <= s.
  - Load carry <= (l ? c_in : 0) and cnt <= 0, then go to RUN.
  - start = 0: remain in IDLE; outputs are held.
- RUN, one bit per clock:
  - Cell inputs are a_sr[0], b_sr[0], carry, l_r, s_r.
  - Each edge: result_sr <= {cell_out, result_sr[N-1:1]}; a_sr and b_sr shift right by 1.
  - carry <= cell c_out when l_r = 1; carry stays 0 when l_r = 0.
  - cnt increments each edge. The edge where cnt == N-1 goes to FIN.
  - Exactly N RUN cycles.
- FIN, one cycle:
  - result <= result_sr, c_out <= carry, zero <= (result_sr == 0), done = 1.
  - Always returns to IDLE on the next edge.
- busy = 1 in RUN and FIN, 0 in IDLE.
- Latency: start sampled at edge E; done is high during the cycle following edge E+N+1; the next start can be accepted at that same edge.
- start while busy is ignored; there is no queueing.
- Operands are captured at start, so later changes to a, b, l, s or c_in have no effect.
- Arithmetic is modulo 2^N; overflow is visible only through c_out.
- result, c_out and zero update only in FIN. They are stable otherwise, including during a following RUN.
- rst_n asserted mid-RUN aborts the operation immediately: no done, all outputs at reset values.

Decomposition:
- Shared package: FSM state encoding (IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2) and the counter width CNT_W = $clog2(N).
- One sub-module: the existing 1-bit ALU cell, instantiated once combinationally.
- Counter, shift registers and FSM are inline in serial_alu_ctl.

Test Plan:
- Reset mid-RUN (N = 8): rst_n low for 1 cycle at bit 3 -> busy = 0, done never pulses, result = 0, zero = 1; a following start completes normally.
- Add (N = 8): a = 0x5A, b = 0x33, l = 1, c_in = 0 -> done after 9 edges, result = 0x8D, c_out = 0, zero = 0.
- Add with carry and overflow: a = 0xFF, b = 0x01, l = 1, c_in = 0 -> result = 0x00, c_out = 1, zero = 1. Same with c_in = 1 -> result = 0x01, c_out = 1.
- Logic ops: a = 0xF0, b = 0x3C, l = 0, each s in 0..3 -> result matches the cell's logic function applied bitwise; c_out = 0 every time.
- start ignored while busy: assert start on every cycle of an add -> exactly one done per N+2 cycles; operands at non-IDLE edges are never used.
- Back-to-back: second start at the edge where done is high -> accepted, and the first result stays held until the second FIN.

Source files
------------

// File: rtl/serial_alu_ctl_pkg.sv
// Shared types for the bit-serial ALU controller: FSM state encoding, logic-unit selects and
// the bit-counter width helper.
package serial_alu_ctl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_e;

  // Logic-unit function chosen by s when the cell is in logic mode (l = 0).
  typedef enum logic [1:0] {
    LuAnd  = 2'd0,
    LuOr   = 2'd1,
    LuXor  = 2'd2,
    LuXnor = 2'd3
  } lu_sel_e;

  // CNT_W = $clog2(N); kept at least 1 so a counter can always be declared.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_alu_ctl_cell.sv
// 1-bit ALU cell: logic unit, full adder and output mux. Purely combinational.
module serial_alu_ctl_cell
  import serial_alu_ctl_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic       l_i,
  input  logic [1:0] s_i,
  output logic       y_o,
  output logic       c_o
);

  logic lu_y;
  logic sum;

  always_comb begin
    lu_y = 1'b0;
    unique case (lu_sel_e'(s_i))
      LuAnd:  lu_y = a_i & b_i;
      LuOr:   lu_y = a_i | b_i;
      LuXor:  lu_y = a_i ^ b_i;
      LuXnor: lu_y = ~(a_i ^ b_i);
      default: lu_y = 1'b0;
    endcase
  end

  always_comb begin
    sum = a_i ^ b_i ^ c_i;
    c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
    y_o = l_i ? sum : lu_y;
  end

endmodule

// File: rtl/serial_alu_ctl.sv
// Bit-serial N-bit ALU controller: latches operands, feeds the 1-bit cell LSB first, collects
// the result and reports it with a one-cycle done pulse.
module serial_alu_ctl
  import serial_alu_ctl_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         l,
  input  logic [1:0]   s,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         c_out,
  output logic         zero
);

  localparam int unsigned CntW = cnt_width(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e state_q, state_d;

  logic [N-1:0]    a_sr_q, a_sr_d;
  logic [N-1:0]    b_sr_q, b_sr_d;
  logic [N-1:0]    res_sr_q, res_sr_d;
  logic            l_q, l_d;
  logic [1:0]      s_q, s_d;
  logic            carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    result_q, result_d;
  logic            c_out_q, c_out_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;

  logic cell_y;
  logic cell_c;

  serial_alu_ctl_cell u_cell (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .l_i (l_q),
    .s_i (s_q),
    .y_o (cell_y),
    .c_o (cell_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (cnt_q == LastCnt) state_d = StFin;
      StFin:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Datapath next state.
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    l_d      = l_q;
    s_d      = s_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          l_d     = l;
          s_d     = s;
          carry_d = l & c_in;
          cnt_d   = '0;
        end
      end
      StRun: begin
        res_sr_d = {cell_y, res_sr_q[N-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        // Logic ops never propagate a carry.
        carry_d  = l_q & cell_c;
        cnt_d    = cnt_q + 1'b1;
      end
      StFin: begin
        result_d = res_sr_q;
        c_out_d  = carry_q;
        zero_d   = (res_sr_q == '0);
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      l_q      <= 1'b0;
      s_q      <= 2'b00;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      l_q      <= l_d;
      s_q      <= s_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_alu_ctl.sv
// Self-checking bench for serial_alu_ctl: fixed vectors, random ops against a word-level
// model, start-while-busy, back-to-back and mid-run reset sequences.
module tb_serial_alu_ctl;

  localparam int unsigned N = 8;
  localparam int unsigned Period = N + 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         l;
  logic [1:0]   s;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         c_out;
  logic         zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] prev_result;

  serial_alu_ctl #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .l      (l),
    .s      (s),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic         vl;
    logic [1:0]   vs;
    logic         vc;
    logic [N-1:0] er;
    logic         ec;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Word-level reference: returns {carry, result}.
  function automatic logic [N:0] ref_op(input logic [N-1:0] ra, input logic [N-1:0] rb,
                                        input logic rl, input logic [1:0] rs, input logic rc);
    logic [N:0] r;
    if (rl) begin
      r = {1'b0, ra} + {1'b0, rb} + (N + 1)'(rc);
    end else begin
      case (rs)
        2'd0:    r = {1'b0, ra & rb};
        2'd1:    r = {1'b0, ra | rb};
        2'd2:    r = {1'b0, ra ^ rb};
        default: r = {1'b0, ~(ra ^ rb)};
      endcase
    end
    return r;
  endfunction

  task automatic scramble();
    a    = N'($urandom);
    b    = N'($urandom);
    l    = 1'($urandom);
    s    = 2'($urandom);
    c_in = 1'($urandom);
  endtask

  // One operation: start at the next negedge, wait (bounded) for done, check everything.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tl,
                       input logic [1:0] ts, input logic tc, input logic [N-1:0] er,
                       input logic ec, input string nm);
    int   edges;
    bit   seen;
    bit   held_ok;
    @(negedge clk);
    a = ta; b = tb_; l = tl; s = ts; c_in = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    scramble();
    edges = 0; seen = 0; held_ok = 1;
    while (!seen && edges < int'(N) + 6) begin
      @(posedge clk);
      #1;
      edges++;
      if (done === 1'b1) seen = 1;
      else if (result !== prev_result || busy !== 1'b1) held_ok = 0;
    end
    check({nm, " done_edge"}, seen ? edges : 0, N + 1);
    check({nm, " held"}, 32'(held_ok), 1);
    check({nm, " result"}, 32'(result), 32'(er));
    check({nm, " c_out"}, 32'(c_out), 32'(ec));
    check({nm, " zero"}, 32'(zero), 32'(er == '0));
    check({nm, " busy_after"}, 32'(busy), 0);
    prev_result = er;
  endtask

  initial begin
    logic [N:0]   r;
    logic [N-1:0] ha[3];
    logic [N-1:0] hb[3];
    logic [1:0]   hs[3];
    int           bad_done;
    int           n_done;
    int           spurious;

    rst_n = 1'b0; start = 1'b0;
    a = '0; b = '0; l = 1'b0; s = 2'b00; c_in = 1'b0;
    prev_result = '0;

    tbl[0] = '{8'h5A, 8'h33, 1'b1, 2'd0, 1'b0, 8'h8D, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b1, 2'd0, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'h01, 1'b1, 2'd0, 1'b1, 8'h01, 1'b1};
    tbl[3] = '{8'hF0, 8'h3C, 1'b0, 2'd0, 1'b1, 8'h30, 1'b0};
    tbl[4] = '{8'hF0, 8'h3C, 1'b0, 2'd1, 1'b1, 8'hFC, 1'b0};
    tbl[5] = '{8'hF0, 8'h3C, 1'b0, 2'd2, 1'b0, 8'hCC, 1'b0};
    tbl[6] = '{8'hF0, 8'h3C, 1'b0, 2'd3, 1'b0, 8'h33, 1'b0};
    tbl[7] = '{8'h80, 8'h80, 1'b1, 2'd2, 1'b0, 8'h00, 1'b1};
    tbl[8] = '{8'h00, 8'h00, 1'b1, 2'd1, 1'b1, 8'h01, 1'b0};

    // Reset state.
    #12;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst result", 32'(result), 0);
    check("rst c_out", 32'(c_out), 0);
    check("rst zero", 32'(zero), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of RUN.
    @(negedge clk);
    a = 8'h5A; b = 8'h33; l = 1'b1; s = 2'd0; c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 0);
    check("midrst result", 32'(result), 0);
    check("midrst zero", 32'(zero), 1);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < int'(N) + 4; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    check("midrst no_done", 32'(spurious), 0);
    prev_result = '0;

    // Fixed vectors; consecutive calls are back-to-back starts.
    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].va, tbl[i].vb, tbl[i].vl, tbl[i].vs, tbl[i].vc, tbl[i].er, tbl[i].ec,
            $sformatf("vec%0d", i));
    end

    // Random operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [N-1:0] ra, rb;
      logic         rl, rc;
      logic [1:0]   rs;
      ra = N'($urandom); rb = N'($urandom); rl = 1'($urandom);
      rs = 2'($urandom); rc = 1'($urandom);
      r = ref_op(ra, rb, rl, rs, rc);
      do_op(ra, rb, rl, rs, rc, r[N-1:0], r[N], $sformatf("rnd%0d", i));
    end

    // start held high continuously: only IDLE edges (every N+2) may capture operands.
    for (int k = 0; k < 3; k++) begin
      ha[k] = N'($urandom); hb[k] = N'($urandom); hs[k] = 2'($urandom);
    end
    bad_done = 0; n_done = 0;
    @(negedge clk);
    a = ha[0]; b = hb[0]; l = 1'b1; s = hs[0]; c_in = 1'b0; start = 1'b1;
    for (int e = 0; e < 3 * int'(Period); e++) begin
      @(posedge clk);
      #1;
      if (e > 0) begin
        if (done === 1'b1) n_done++;
        if ((done === 1'b1) != ((e % int'(Period)) == int'(N) + 1)) bad_done++;
        if ((e % int'(Period)) == int'(N) + 1) begin
          r = ref_op(ha[e / int'(Period)], hb[e / int'(Period)], 1'b1, hs[e / int'(Period)], 1'b0);
          check($sformatf("hold%0d result", e / int'(Period)), 32'(result), 32'(r[N-1:0]));
          check($sformatf("hold%0d c_out", e / int'(Period)), 32'(c_out), 32'(r[N]));
        end
      end
      @(negedge clk);
      if (e + 1 == 3 * int'(Period)) begin
        start = 1'b0;
      end else if (((e + 1) % int'(Period)) == 0) begin
        a = ha[(e + 1) / int'(Period)]; b = hb[(e + 1) / int'(Period)];
        l = 1'b1; s = hs[(e + 1) / int'(Period)]; c_in = 1'b0;
      end else begin
        scramble();
      end
    end
    check("hold done_count", 32'(n_done), 3);
    check("hold done_timing", 32'(bad_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
